// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    localparam int HDR_W = 16;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/imem_byte_writer.sv
// rtl/imem_byte_writer.sv - registered byte write port with sequential address generation
module imem_byte_writer
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [7:0]        data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [HDR_W-1:0]  count
);

    // The address is taken from the pre-increment count so payload byte k lands at BASE_ADDR+k.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_W'(BASE_ADDR);
            mem_wdata <= 8'd0;
            count     <= '0;
        end else begin
            mem_we <= wr;
            if (clr) begin
                count <= '0;
            end else if (wr) begin
                mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(count);
                mem_wdata <= data;
                count     <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 512,
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       byte_count
);

    state_t             state, state_n;
    logic [HDR_W-1:0]   length;
    logic [7:0]         csum;
    logic [1:0]         ecode;
    logic               accept;
    logic [HDR_W-1:0]   len_n;
    logic [ADDR_W:0]    frame_end;
    logic               overflow;
    logic               last_byte;

    assign accept    = in_valid && in_ready;
    assign len_n     = {length[15:8], in_data};
    // One extra bit keeps BASE_ADDR + N from wrapping before the compare.
    assign frame_end = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(len_n);
    assign overflow  = frame_end > (ADDR_W+1)'(DEPTH);
    assign last_byte = (byte_count + 16'd1) == length;

    imem_byte_writer #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_writer (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept && state == LEN_HI),
        .wr       (accept && state == DATA),
        .data     (in_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .count    (byte_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LEN_HI;
            length <= '0;
            csum   <= 8'd0;
            ecode  <= ERR_NONE;
        end else begin
            state <= state_n;
            case (state)
                LEN_HI: if (accept) begin
                    length[15:8] <= in_data;
                    csum         <= 8'd0;
                end
                LEN_LO: if (accept) begin
                    length[7:0] <= in_data;
                    if (overflow) ecode <= ERR_LEN;
                end
                DATA:   if (accept) csum <= csum ^ in_data;
                CSUM:   if (accept && in_data != csum) ecode <= ERR_CSUM;
                DONE, ERR: if (clear) ecode <= ERR_NONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            LEN_HI: if (accept) state_n = LEN_LO;
            LEN_LO: if (accept) begin
                if (overflow)        state_n = ERR;
                else if (len_n == 0) state_n = CSUM;
                else                 state_n = DATA;
            end
            DATA:   if (accept && last_byte) state_n = CSUM;
            CSUM:   if (accept) state_n = (in_data == csum) ? DONE : ERR;
            DONE, ERR: if (clear) state_n = LEN_HI;
            default: state_n = LEN_HI;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        err_code = ecode;
        case (state)
            LEN_HI:         in_ready = 1'b1;
            LEN_LO, DATA, CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR:            err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 32;
    localparam int BASE   = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              clear;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [15:0]       byte_count;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .err_code(err_code),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [7:0]  data;
        int unsigned at;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int          n_writes = 0;
    wr_t         exp_q[$];
    logic [7:0]  payload[$];
    logic [7:0]  tb_mem[DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_t e;
            n_writes++;
            tb_mem[mem_addr[8:0]] = mem_wdata;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
                chk("wr_cycle", cyc, e.at);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit is_data, input int k, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin
                if (is_data) exp_q.push_back('{BASE + k, b, cyc + 1});
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_frame(input int gmin, input int gmax, input bit bad);
        logic [15:0] len;
        logic [7:0]  x;
        len = 16'(payload.size());
        x   = 8'd0;
        send_byte(len[15:8], 0, 0, $urandom_range(gmax, gmin));
        send_byte(len[7:0], 0, 0, $urandom_range(gmax, gmin));
        for (int k = 0; k < payload.size(); k++) begin
            x ^= payload[k];
            send_byte(payload[k], 1, k, $urandom_range(gmax, gmin));
        end
        send_byte(bad ? (x ^ 8'h01) : x, 0, 0, $urandom_range(gmax, gmin));
    endtask

    task automatic check_status(input bit d, input bit e, input int code, input int cnt);
        chk("done", {31'd0, done}, {31'd0, d});
        chk("err", {31'd0, err}, {31'd0, e});
        chk("err_code", {30'd0, err_code}, code);
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !d});
        chk("busy", {31'd0, busy}, 32'd0);
        chk("in_ready", {31'd0, in_ready}, 32'd0);
        chk("byte_count", {16'd0, byte_count}, cnt);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_done", {31'd0, done}, 32'd0);
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_err_code", {30'd0, err_code}, 32'd0);
        chk("clr_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset();
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_byte_count", {16'd0, byte_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic rand_payload(input int n);
        payload.delete();
        for (int k = 0; k < n; k++) payload.push_back(8'($urandom));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n;
        bit bad;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset();

        // Normal load and readback of the first instruction word.
        payload = '{8'h13, 8'h00, 8'h00, 8'h93};
        send_frame(0, 0, 0);
        check_status(1, 0, 0, 4);
        chk("imem_word0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'h13000093);
        do_clear();

        // Checksum mismatch still writes the payload.
        w0 = n_writes;
        send_frame(0, 0, 1);
        check_status(0, 1, 2, 4);
        chk("csum_err_writes", n_writes - w0, 4);
        do_clear();

        // Length overflow: 513 bytes does not fit.
        w0 = n_writes;
        send_byte(8'h02, 0, 0, 0);
        send_byte(8'h01, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'h5a;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check_status(0, 1, 1, 0);
        chk("ovf_writes", n_writes - w0, 0);
        do_clear();

        // Zero-length frame.
        w0 = n_writes;
        payload.delete();
        send_frame(0, 0, 0);
        check_status(1, 0, 0, 0);
        chk("zero_writes", n_writes - w0, 0);
        do_clear();

        // Backpressure: one idle cycle before every byte.
        rand_payload(8);
        send_frame(1, 1, 0);
        check_status(1, 0, 0, 8);
        do_clear();

        // Reset after two of four payload bytes.
        rand_payload(4);
        send_byte(8'h00, 0, 0, 0);
        send_byte(8'h04, 0, 0, 0);
        send_byte(payload[0], 1, 0, 0);
        send_byte(payload[1], 1, 1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset();
        payload = '{8'hde, 8'had, 8'hbe, 8'hef};
        send_frame(0, 0, 0);
        check_status(1, 0, 0, 4);
        chk("reload_word0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'hdeadbeef);
        do_clear();

        // Clear during DATA is ignored.
        payload = '{8'h11, 8'h22, 8'h44};
        send_byte(8'h00, 0, 0, 0);
        send_byte(8'h03, 0, 0, 0);
        send_byte(payload[0], 1, 0, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("data_clear_busy", {31'd0, busy}, 32'd1);
        chk("data_clear_ready", {31'd0, in_ready}, 32'd1);
        send_byte(payload[1], 1, 1, 0);
        send_byte(payload[2], 1, 2, 0);
        send_byte(8'h11 ^ 8'h22 ^ 8'h44, 0, 0, 0);
        check_status(1, 0, 0, 3);
        do_clear();

        // Largest frame that fits exactly.
        rand_payload(DEPTH - BASE);
        send_frame(0, 0, 0);
        check_status(1, 0, 0, DEPTH - BASE);
        do_clear();

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(7, 0) == 0) begin
                n = $urandom_range(1000, DEPTH - BASE + 1);
                send_byte(8'(n >> 8), 0, 0, $urandom_range(2, 0));
                send_byte(8'(n), 0, 0, $urandom_range(2, 0));
                check_status(0, 1, 1, 0);
            end else begin
                n   = $urandom_range(24, 0);
                bad = ($urandom_range(3, 0) == 0);
                rand_payload(n);
                send_frame(0, 2, bad);
                check_status(!bad, bad, bad ? 2 : 0, n);
            end
            do_clear();
        end

        repeat (3) @(negedge clk);
        chk("pending_writes", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
